// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU result-collection path.
//   - opcode_e       : ALSU opcode encoding
//   - is_invalid()   : decides at issue time whether an operation is invalid
//   - result_entry_t : one captured result as stored in the result FIFO
package alsu_pkg;

  localparam int ALSU_OUT_W = 6;
  localparam int ALSU_OPC_W = 3;
  localparam int ALSU_TAG_W = 4;

  typedef enum logic [ALSU_OPC_W-1:0] {
    OR        = 3'd0,
    XOR       = 3'd1,
    ADD       = 3'd2,
    MULT      = 3'd3,
    SHIFT     = 3'd4,
    ROTATE    = 3'd5,
    INVALID_6 = 3'd6,
    INVALID_7 = 3'd7
  } opcode_e;

  typedef struct packed {
    logic [ALSU_OUT_W-1:0] out;
    logic [ALSU_OPC_W-1:0] opcode;
    logic [ALSU_TAG_W-1:0] tag;
    logic                  inv;
  } result_entry_t;

  // Opcodes 6/7 are never legal. A reduction request is only meaningful for
  // OR/XOR, so combining it with any arithmetic/shift opcode is invalid.
  function automatic logic is_invalid(input logic [ALSU_OPC_W-1:0] opcode,
                                      input logic                  red_op);
    logic inv;
    case (opcode_e'(opcode))
      INVALID_6, INVALID_7:     inv = 1'b1;
      ADD, MULT, SHIFT, ROTATE: inv = red_op;
      default:                  inv = 1'b0;
    endcase
    return inv;
  endfunction

endpackage

// File: rtl/alsu_result_fifo.sv
// First-word fall-through FIFO for captured ALSU results.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   push       : write request; push_data is the entry to store
//   pop        : read request; ignored while empty
//   head       : current head entry (all zero while empty)
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
//   accepted   : push was written this cycle
//   dropped    : push was discarded because the FIFO was full with no pop
module alsu_result_fifo
  import alsu_pkg::*;
#(
  parameter type entry_t = result_entry_t,
  parameter int  DEPTH   = 8,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             accepted,
  output logic             dropped
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             pop_eff;
  logic             push_eff;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign pop_eff  = pop && !empty;
  // A pop in the same edge frees the slot, so a push into a full FIFO
  // still succeeds when the head is leaving.
  assign push_eff = push && (!full || pop_eff);
  assign accepted = push_eff;
  assign dropped  = push && !push_eff;
  assign count    = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({push_eff, pop_eff})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Storage carries no reset; emptiness is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_reg] <= push_data;
  end

  // Fall-through read; forced to zero when empty so stale data never shows.
  assign head = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/alsu_result_collector.sv
// Collects ALSU results: follows each issued operation through the ALSU's
// fixed latency, captures the matching `out`, and queues it for a consumer.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   issue_valid/opcode/red_op/tag : operation applied to the ALSU this cycle
//   alsu_out            : ALSU result bus
//   res_valid/ready     : consumer handshake on the FIFO head
//   res_data/opcode/tag/invalid : head entry fields
//   count               : FIFO occupancy
//   overflow            : sticky, set when a capture was dropped
//   invalid_cnt         : saturating count of captured invalid operations
//   clear_stat          : synchronous clear of overflow and invalid_cnt
module alsu_result_collector
  import alsu_pkg::*;
#(
  parameter int OUT_W   = ALSU_OUT_W,
  parameter int OPC_W   = ALSU_OPC_W,
  parameter int TAG_W   = ALSU_TAG_W,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [OPC_W-1:0]           issue_opcode,
  input  logic                       issue_red_op,
  input  logic [TAG_W-1:0]           issue_tag,
  input  logic [OUT_W-1:0]           alsu_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [OUT_W-1:0]           res_data,
  output logic [OPC_W-1:0]           res_opcode,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       res_invalid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [7:0]                 invalid_cnt,
  input  logic                       clear_stat
);

  typedef struct packed {
    logic             valid;
    logic [OPC_W-1:0] opcode;
    logic [TAG_W-1:0] tag;
    logic             inv;
  } stage_t;

  typedef struct packed {
    logic [OUT_W-1:0] out;
    logic [OPC_W-1:0] opcode;
    logic [TAG_W-1:0] tag;
    logic             inv;
  } entry_t;

  stage_t                 stage_in;
  stage_t [LATENCY-1:0]   stage_reg;
  stage_t                 tail;
  entry_t                 push_entry;
  entry_t                 head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_accepted;
  logic                   fifo_dropped;
  logic                   overflow_reg;
  logic [7:0]             invalid_cnt_reg;

  always_comb begin
    stage_in        = '0;
    stage_in.valid  = issue_valid;
    stage_in.opcode = issue_opcode;
    stage_in.tag    = issue_tag;
    stage_in.inv    = is_invalid(ALSU_OPC_W'(issue_opcode), issue_red_op);
  end

  // Stage 0 loads at the issue edge; after LATENCY-1 further edges the entry
  // sits in the last stage, so it is captured at issue edge + LATENCY,
  // the same edge at which the ALSU result is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= stage_in;
      for (int i = 1; i < LATENCY; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign tail = stage_reg[LATENCY-1];

  always_comb begin
    push_entry        = '0;
    push_entry.out    = alsu_out;
    push_entry.opcode = tail.opcode;
    push_entry.tag    = tail.tag;
    push_entry.inv    = tail.inv;
  end

  alsu_result_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tail.valid),
    .push_data (push_entry),
    .pop       (res_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count),
    .accepted  (fifo_accepted),
    .dropped   (fifo_dropped)
  );

  // Clear takes priority so software can zero the stats without racing
  // against traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg    <= 1'b0;
      invalid_cnt_reg <= '0;
    end else if (clear_stat) begin
      overflow_reg    <= 1'b0;
      invalid_cnt_reg <= '0;
    end else begin
      if (fifo_dropped) overflow_reg <= 1'b1;
      // Only entries that actually made it into the FIFO are counted.
      if (fifo_accepted && push_entry.inv && (invalid_cnt_reg != 8'hFF)) begin
        invalid_cnt_reg <= invalid_cnt_reg + 8'd1;
      end
    end
  end

  assign res_valid   = !fifo_empty;
  assign res_data    = head.out;
  assign res_opcode  = head.opcode;
  assign res_tag     = head.tag;
  assign res_invalid = head.inv;
  assign overflow    = overflow_reg;
  assign invalid_cnt = invalid_cnt_reg;

endmodule

// File: doc/alsu_result_collector.md
Name: alsu_result_collector

Overview:
- Downstream stage of the ALSU. Tracks each issued operation through the ALSU's fixed 2-cycle latency and captures the matching `out` value with its opcode, tag and invalid flag.
- Buffers captured results in a FIFO and presents them to a consumer over a valid/ready handshake.
- Gives the system and the bench one ordered, lossless-or-flagged result stream.

Parameters:
- OUT_W, 6, width of ALSU `out`
- OPC_W, 3, opcode width
- TAG_W, 4, issue tag width
- LATENCY, 2, ALSU input-to-output latency in clock edges (must be >= 1)
- DEPTH, 8, FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- issue_valid  in  1  high in the cycle operands/controls are applied to the ALSU
- issue_opcode  in  OPC_W  opcode applied that cycle
- issue_red_op  in  1  red_op_A | red_op_B applied that cycle
- issue_tag  in  TAG_W  caller-assigned identifier
- alsu_out  in  OUT_W  ALSU `out`
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accepts head
- res_data  out  OUT_W  captured `out`
- res_opcode  out  OPC_W  opcode of head entry
- res_tag  out  TAG_W  tag of head entry
- res_invalid  out  1  head entry was an invalid operation
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- overflow  out  1  sticky: a capture was dropped
- invalid_cnt  out  8  saturating count of captured invalid ops
- clear_stat  in  1  synchronous clear of overflow and invalid_cnt

Behaviour:
- Reset (rst=0, asynchronous):
  - delay line cleared; FIFO emptied.
  - res_valid=0, res_data=0, res_opcode=0, res_tag=0, res_invalid=0, count=0, overflow=0, invalid_cnt=0.
  - Reset mid-flight discards all in-flight and buffered entries.
- Invalid rule, computed at issue:
  - inv = (opcode==6 || opcode==7) || (issue_red_op && opcode in {2,3,4,5}).
- Delay line:
  - LATENCY-stage shift register of {valid, opcode, tag, inv}.
  - Stage 1 loads the issue_* inputs every edge.
  - Issue sampled at edge t reaches the final stage so that at edge t+LATENCY the final stage holds that entry.
  - At that edge, alsu_out is sampled together with the entry, exactly aligned with the ALSU contract "inputs at t, out checked at t+2".
- Capture (push): at every edge where the final stage is valid.
- FIFO behaviour:
  - First-word fall-through: res_* reflect the head entry whenever count!=0.
  - res_valid = (count!=0).
  - Pop on res_valid && res_ready at an edge.
  - Pop while empty is a no-op.
  - Push while full and no pop in the same edge: entry dropped, overflow set to 1, count unchanged.
  - Push and pop in the same edge while full: both occur, no drop, count stays DEPTH.
  - Push and pop in the same edge while count==1: head replaced by the new entry, count stays 1.
  - Read/write pointers wrap modulo DEPTH; count never exceeds DEPTH.
- Latency: issue at edge t into an empty FIFO gives res_valid=1 after edge t+LATENCY, holding that capture.
- Back-to-back issue every cycle sustains one capture per cycle; order is preserved.
- invalid_cnt:
  - increments by 1 at each accepted push with inv=1.
  - saturates at 255.
  - dropped entries are not counted.
- clear_stat=1 at an edge:
  - overflow and invalid_cnt become 0.
  - clear wins over a simultaneous set or increment.
  - the FIFO is unaffected.
- res_* outputs are stable while res_valid=1 and res_ready=0.

Decomposition:
- Shared package alsu_pkg:
  - opcode enum: OR=0, XOR=1, ADD=2, MULT=3, SHIFT=4, ROTATE=5, INVALID_6=6, INVALID_7=7.
  - function is_invalid(opcode, red_op).
  - packed struct result_entry_t {out, opcode, tag, inv}.
- One sub-module: alsu_result_fifo, a parameterised FWFT FIFO of result_entry_t with push/pop/full/empty/count.
- The delay line and stats stay in the top module.

Test Plan:
- Basic capture: issue_valid=1, opcode=2, tag=5 at edge t, alsu_out=6'd9 at edge t+2 -> after t+2: res_valid=1, res_data=9, res_opcode=2, res_tag=5, res_invalid=0, count=1.
- Invalid ops: issue opcode=6, then opcode=3 with issue_red_op=1 -> both captured with res_invalid=1, invalid_cnt=2; opcode=0 with red_op=1 captured with res_invalid=0.
- Back-to-back: 8 consecutive issues, tags 0..7, res_ready=0 -> count=8, overflow=0. A 9th issue -> overflow=1, count=8. Draining returns tags 0..7 in order.
- Full with simultaneous push/pop: FIFO full, res_ready=1 on the same edge as a capture -> no drop, overflow stays 0, count stays 8.
- Reset mid-flight: two issues in flight and three buffered, rst=0 for half a cycle -> count=0, res_valid=0, all outputs 0 immediately. No capture appears 2 cycles later.
- Stats: drive invalid_cnt to 255 with 260 invalid ops (draining continuously) -> stays 255. clear_stat=1 concurrent with an invalid push -> invalid_cnt=0, overflow=0.
